i2c_slave_regbus: RTL and testbench

//  Parametrised, fully synchronous I2C slave that bridges I2C to a local register bus.
//  SCL/SDA are oversampled on clk, so no logic is clocked by SCL or SDA.

---
 rtl/i2c_slave_regbus.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_slave_regbus.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbus.sv
// I2C slave bridging an oversampled SCL/SDA pair to a local register bus.
// Supports pointer byte, auto-increment with optional wrap and repeated START.
module i2c_slave_regbus #(
    parameter logic [6:0] SLV_ADDR = 7'h10,
    parameter int         DEPTH    = 16,
    parameter int         FILT     = 3,
    parameter int         HOLD     = 4,
    parameter bit         WRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int FW = $clog2(FILT + 1);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADR_ACK, S_PTR, S_PTR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK
    } state_t;

    logic [1:0]    scl_s_q, sda_s_q;
    logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;
    logic [FW-1:0] scl_c_q, sda_c_q;
    logic [HW-1:0] hold_q;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [7:0] sr_q, rsh_q, wdata_q;
    logic [8:0] ptr_q;
    logic [1:0] ld_q;
    logic       rw_q, drv_q, ack_q, got_q;
    logic       oe_q, we_q, re_q, busy_q;

    logic       scl_rise, scl_fall, start_c, stop_c, fall_d, in_rng;
    logic [7:0] nxt_byte;

    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start_c  = ~sda_f_q & sda_p_q & scl_f_q & scl_p_q;
    assign stop_c   = sda_f_q & ~sda_p_q & scl_f_q & scl_p_q;
    assign fall_d   = (hold_q == HW'(1));
    assign in_rng   = (ptr_q < 9'(DEPTH));
    assign nxt_byte = {sr_q[6:0], sda_f_q};

    assign sda_oe    = oe_q;
    assign reg_addr  = ptr_q[7:0];
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;

    function automatic logic [8:0] ptr_inc(input logic [8:0] p);
        if (p == 9'(DEPTH - 1))
            return WRAP ? 9'd0 : 9'(DEPTH);
        else if (p >= 9'(DEPTH))
            return p;
        else
            return p + 9'd1;
    endfunction

    // Synchronise pins and accept a new level only after FILT equal samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s_q <= 2'b11;
            sda_s_q <= 2'b11;
            scl_f_q <= 1'b1;
            sda_f_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
            scl_c_q <= '0;
            sda_c_q <= '0;
        end else begin
            scl_s_q <= {scl_s_q[0], scl_i};
            sda_s_q <= {sda_s_q[0], sda_i};
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            if (scl_s_q[1] == scl_f_q) begin
                scl_c_q <= '0;
            end else if (scl_c_q == FW'(FILT - 1)) begin
                scl_f_q <= scl_s_q[1];
                scl_c_q <= '0;
            end else begin
                scl_c_q <= scl_c_q + 1'b1;
            end
            if (sda_s_q[1] == sda_f_q) begin
                sda_c_q <= '0;
            end else if (sda_c_q == FW'(FILT - 1)) begin
                sda_f_q <= sda_s_q[1];
                sda_c_q <= '0;
            end else begin
                sda_c_q <= sda_c_q + 1'b1;
            end
        end
    end

    // Delay each SCL fall by HOLD clocks before SDA may change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (scl_fall) begin
            hold_q <= HW'(HOLD);
        end else if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
        end
    end

    // Protocol FSM with registered bus strobes and SDA drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            rsh_q   <= 8'hFF;
            wdata_q <= '0;
            ptr_q   <= '0;
            ld_q    <= '0;
            rw_q    <= 1'b0;
            drv_q   <= 1'b0;
            ack_q   <= 1'b0;
            got_q   <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            ld_q <= {ld_q[0], 1'b0};
            if (ld_q[1])
                rsh_q <= in_rng ? reg_rdata : 8'hFF;
            if (we_q)
                ptr_q <= ptr_inc(ptr_q);
            if (stop_c) begin
                state_q <= S_IDLE;
                oe_q    <= 1'b0;
                drv_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else if (start_c) begin
                state_q <= S_ADDR;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                drv_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_ADDR, S_PTR, S_WR: begin
                        if (fall_d)
                            oe_q <= 1'b0;
                        if (scl_rise) begin
                            sr_q  <= nxt_byte;
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                drv_q <= 1'b0;
                                if (state_q == S_ADDR) begin
                                    if (nxt_byte[7:1] == SLV_ADDR &&
                                        nxt_byte[7:1] != 7'd0) begin
                                        state_q <= S_ADR_ACK;
                                        rw_q    <= nxt_byte[0];
                                        ack_q   <= 1'b1;
                                        busy_q  <= 1'b1;
                                    end else begin
                                        state_q <= S_IDLE;
                                        oe_q    <= 1'b0;
                                        busy_q  <= 1'b0;
                                    end
                                end else if (state_q == S_PTR) begin
                                    if ({1'b0, nxt_byte} < 9'(DEPTH)) begin
                                        ptr_q   <= {1'b0, nxt_byte};
                                        ack_q   <= 1'b1;
                                        state_q <= S_PTR_ACK;
                                    end else begin
                                        state_q <= S_IDLE;
                                    end
                                end else begin
                                    ack_q   <= in_rng;
                                    we_q    <= in_rng;
                                    wdata_q <= in_rng ? nxt_byte : wdata_q;
                                    state_q <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    S_ADR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (fall_d && !drv_q) begin
                            oe_q  <= ack_q;
                            drv_q <= 1'b1;
                        end
                        if (scl_fall && drv_q) begin
                            cnt_q <= '0;
                            drv_q <= 1'b0;
                            if (state_q == S_ADR_ACK && rw_q) begin
                                state_q <= S_RD;
                                re_q    <= in_rng;
                                ld_q    <= 2'b01;
                            end else if (state_q == S_ADR_ACK) begin
                                state_q <= S_PTR;
                            end else begin
                                state_q <= S_WR;
                            end
                        end
                    end
                    S_RD: begin
                        if (fall_d) begin
                            oe_q  <= ~rsh_q[7];
                            rsh_q <= {rsh_q[6:0], 1'b1};
                        end
                        if (scl_rise) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                state_q <= S_RD_ACK;
                                got_q   <= 1'b0;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (fall_d)
                            oe_q <= 1'b0;
                        if (scl_rise) begin
                            if (!sda_f_q) begin
                                got_q <= 1'b1;
                                ptr_q <= ptr_inc(ptr_q);
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                        if (scl_fall && got_q) begin
                            got_q   <= 1'b0;
                            re_q    <= in_rng;
                            ld_q    <= 2'b01;
                            cnt_q   <= '0;
                            state_q <= S_RD;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regbus.sv
// Bench for i2c_slave_regbus: bit-banged I2C master, register files, checks.
// Second instance with WRAP=0 covers the no-wrap pointer boundary.
module tb_i2c_slave_regbus;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic       oe_a, we_a, re_a, busy_a;
    logic [7:0] addr_a, wdata_a, rdata_a;
    logic       oe_b, we_b, re_b, busy_b;
    logic [7:0] addr_b, wdata_b, rdata_b;
    logic       scl_a, sda_a, scl_b, sda_b, line;

    assign scl_a = sel ? 1'b1 : scl_m;
    assign sda_a = (sel ? 1'b1 : sda_m) & ~oe_a;
    assign scl_b = sel ? scl_m : 1'b1;
    assign sda_b = (sel ? sda_m : 1'b1) & ~oe_b;
    assign line  = sel ? sda_b : sda_a;

    i2c_slave_regbus dut (
        .clk(clk), .rst(rst), .scl_i(scl_a), .sda_i(sda_a),
        .sda_oe(oe_a), .reg_addr(addr_a), .reg_wdata(wdata_a),
        .reg_we(we_a), .reg_re(re_a), .reg_rdata(rdata_a), .busy(busy_a)
    );

    i2c_slave_regbus #(.WRAP(1'b0)) dut_nw (
        .clk(clk), .rst(rst), .scl_i(scl_b), .sda_i(sda_b),
        .sda_oe(oe_b), .reg_addr(addr_b), .reg_wdata(wdata_b),
        .reg_we(we_b), .reg_re(re_b), .reg_rdata(rdata_b), .busy(busy_b)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int we_cnt_a = 0, re_cnt_a = 0, we_cnt_b = 0;
    int oe_cnt_a = 0, busy_cnt_a = 0, clash = 0;

    // Register files on the local bus side, plus strobe bookkeeping.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'(i * 7 + 3);
                mem_b[i] <= 8'(i * 7 + 3);
            end
            rdata_a <= 8'h00;
            rdata_b <= 8'h00;
        end else begin
            if (we_a) mem_a[addr_a] <= wdata_a;
            if (re_a) rdata_a <= mem_a[addr_a];
            if (we_b) mem_b[addr_b] <= wdata_b;
            if (re_b) rdata_b <= mem_b[addr_b];
        end
        we_cnt_a   <= we_cnt_a + int'(we_a);
        re_cnt_a   <= re_cnt_a + int'(re_a);
        we_cnt_b   <= we_cnt_b + int'(we_b);
        oe_cnt_a   <= oe_cnt_a + int'(oe_a);
        busy_cnt_a <= busy_cnt_a + int'(busy_a);
        clash      <= clash + int'((we_a & re_a) | (we_b & re_b));
    end

    int n_pass = 0, n_total = 0;
    logic [7:0] mem_m [16];
    int pm;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_w(input logic b);
        tick(10); sda_m = b; tick(10); scl_m = 1'b1; tick(20); scl_m = 1'b0;
    endtask

    task automatic bit_r(output logic b);
        tick(10); sda_m = 1'b1; tick(10); scl_m = 1'b1;
        tick(10); b = line; tick(10); scl_m = 1'b0;
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(b);
        ack = ~b;
    endtask

    task automatic byte_wg(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) begin
                tick(5); scl_m = 1'b1; tick(1); scl_m = 1'b0;
            end
            bit_w(d[i]);
        end
        bit_r(b);
        ack = ~b;
    endtask

    task automatic byte_r(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        bit_w(~ack);
    endtask

    task automatic i2c_start;
        tick(10); sda_m = 1'b1; tick(10); scl_m = 1'b1;
        tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b1;
        tick(10); sda_m = 1'b1; tick(20);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       aack;
        logic       pack;
        logic       dack;
        int         nwe;
    } vec_t;

    vec_t tv [6];

    initial begin
        logic a;
        logic [7:0] d, d0, d1;
        int w0, r0, o0, b0;

        tv[0] = '{8'h20, 8'h03, 8'hA5, 1'b1, 1'b1, 1'b1, 1};
        tv[1] = '{8'h22, 8'h03, 8'h11, 1'b0, 1'b0, 1'b0, 0};
        tv[2] = '{8'h20, 8'h10, 8'h22, 1'b1, 1'b0, 1'b0, 0};
        tv[3] = '{8'h20, 8'h0F, 8'h3C, 1'b1, 1'b1, 1'b1, 1};
        tv[4] = '{8'h00, 8'h01, 8'h44, 1'b0, 1'b0, 1'b0, 0};
        tv[5] = '{8'h20, 8'hFF, 8'h66, 1'b1, 1'b0, 1'b0, 0};
        for (int i = 0; i < 16; i++) mem_m[i] = 8'(i * 7 + 3);

        tick(3);
        chk("rst_sda_oe", oe_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_re", re_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_busy", busy_a, 0);
        init = 1'b0;
        rst = 1'b0;
        tick(10);

        for (int i = 0; i < 6; i++) begin
            w0 = we_cnt_a;
            i2c_start;
            byte_w(tv[i].addr, a);
            chk("tv_addr_ack", a, tv[i].aack);
            if (tv[i].aack) begin
                byte_w(tv[i].ptr, a);
                chk("tv_ptr_ack", a, tv[i].pack);
            end
            if (tv[i].pack) begin
                byte_w(tv[i].data, a);
                chk("tv_data_ack", a, tv[i].dack);
            end
            i2c_stop;
            chk("tv_we_count", we_cnt_a - w0, tv[i].nwe);
            if (tv[i].nwe != 0) begin
                chk("tv_mem", mem_a[tv[i].ptr], tv[i].data);
                mem_m[tv[i].ptr[3:0]] = tv[i].data;
            end
        end

        // Two-byte write with busy tracking.
        w0 = we_cnt_a;
        i2c_start;
        byte_w(8'h20, a); chk("t1_aack", a, 1);
        chk("t1_busy", busy_a, 1);
        byte_w(8'h03, a); chk("t1_pack", a, 1);
        byte_w(8'hA5, a); chk("t1_d0ack", a, 1);
        byte_w(8'h5A, a); chk("t1_d1ack", a, 1);
        i2c_stop;
        chk("t1_busy_stop", busy_a, 0);
        chk("t1_we_count", we_cnt_a - w0, 2);
        chk("t1_mem3", mem_a[3], 8'hA5);
        chk("t1_mem4", mem_a[4], 8'h5A);
        mem_m[3] = 8'hA5;
        mem_m[4] = 8'h5A;

        // Read across the wrap point via repeated START.
        r0 = re_cnt_a;
        i2c_start;
        byte_w(8'h20, a); chk("t2_aack", a, 1);
        byte_w(8'h0F, a); chk("t2_pack", a, 1);
        i2c_start;
        byte_w(8'h21, a); chk("t2_raack", a, 1);
        byte_r(d0, 1'b1);
        byte_r(d1, 1'b0);
        i2c_stop;
        chk("t2_byte15", d0, mem_m[15]);
        chk("t2_byte0", d1, mem_m[0]);
        chk("t2_re_count", re_cnt_a - r0, 2);

        // Foreign address leaves the bus untouched.
        w0 = we_cnt_a; r0 = re_cnt_a; o0 = oe_cnt_a; b0 = busy_cnt_a;
        i2c_start;
        byte_w(8'h22, a); chk("t3_nack", a, 0);
        i2c_stop;
        chk("t3_oe", oe_cnt_a - o0, 0);
        chk("t3_busy", busy_cnt_a - b0, 0);
        chk("t3_strobes", (we_cnt_a - w0) + (re_cnt_a - r0), 0);

        // No-wrap instance: write then read past the last register.
        tick(5); sel = 1'b1; tick(5);
        w0 = we_cnt_b;
        i2c_start;
        byte_w(8'h20, a); chk("t4_aack", a, 1);
        byte_w(8'h0F, a); chk("t4_pack", a, 1);
        byte_w(8'h77, a); chk("t4_d0ack", a, 1);
        byte_w(8'h88, a); chk("t4_d1nack", a, 0);
        i2c_stop;
        chk("t4_we_count", we_cnt_b - w0, 1);
        chk("t4_mem15", mem_b[15], 8'h77);
        i2c_start;
        byte_w(8'h20, a);
        byte_w(8'h0F, a);
        i2c_start;
        byte_w(8'h21, a); chk("t4_raack", a, 1);
        byte_r(d0, 1'b1);
        byte_r(d1, 1'b0);
        i2c_stop;
        chk("t4_rd15", d0, 8'h77);
        chk("t4_rd_beyond", d1, 8'hFF);
        tick(5); sel = 1'b0; tick(5);

        // SCL glitch inside the address byte.
        w0 = we_cnt_a;
        i2c_start;
        byte_wg(8'h20, a); chk("t5_glitch_aack", a, 1);
        byte_w(8'h07, a); chk("t5_pack", a, 1);
        byte_w(8'h96, a); chk("t5_dack", a, 1);
        i2c_stop;
        chk("t5_we_count", we_cnt_a - w0, 1);
        chk("t5_mem7", mem_a[7], 8'h96);
        mem_m[7] = 8'h96;

        // Reset while the slave drives the data ACK.
        w0 = we_cnt_a;
        i2c_start;
        byte_w(8'h20, a);
        byte_w(8'h05, a);
        for (int i = 7; i >= 0; i--) bit_w(d0[0] | 1'b1 ? 1'(8'hC3 >> i) : 1'b0);
        for (int k = 0; k < 40 && !oe_a; k++) tick(1);
        chk("t5_ack_driven", oe_a, 1);
        #3 rst = 1'b1;
        #1 chk("t5_rst_oe", oe_a, 0);
        chk("t5_rst_busy", busy_a, 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        i2c_stop;
        chk("t5_rst_we", we_cnt_a - w0, 1);
        mem_m[5] = 8'hC3;

        // STOP in the middle of a data byte.
        w0 = we_cnt_a;
        i2c_start;
        byte_w(8'h20, a); chk("t6_aack", a, 1);
        byte_w(8'h02, a); chk("t6_pack", a, 1);
        bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
        i2c_stop;
        chk("t6_we", we_cnt_a - w0, 0);
        chk("t6_oe", oe_a, 0);
        chk("t6_busy", busy_a, 0);

        // Random writes and reads against the array model.
        for (int t = 0; t < 12; t++) begin
            int n;
            bit rd;
            pm = $urandom_range(0, 15);
            n  = $urandom_range(1, 3);
            rd = 1'($urandom_range(0, 1));
            i2c_start;
            byte_w(8'h20, a); chk("rnd_aack", a, 1);
            byte_w(8'(pm), a); chk("rnd_pack", a, 1);
            if (!rd) begin
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    byte_w(d, a); chk("rnd_dack", a, 1);
                    mem_m[pm] = d;
                    pm = (pm + 1) % 16;
                end
            end else begin
                i2c_start;
                byte_w(8'h21, a); chk("rnd_raack", a, 1);
                for (int k = 0; k < n; k++) begin
                    byte_r(d, k != n - 1);
                    chk("rnd_rdata", d, mem_m[pm]);
                    pm = (pm + 1) % 16;
                end
            end
            i2c_stop;
        end

        for (int i = 0; i < 16; i++) chk("final_mem", mem_a[i], mem_m[i]);
        chk("we_re_overlap", clash, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
